des_iter_ctrl: RTL and testbench

Sequencing controller for the iterative DES datapath. It accepts one 64-bit block job at a time through a valid/ready handshake and pulses the datapath load. It then runs 16 Feistel rounds, one per clock, and drives the key-schedule rotation amount and direction for each round. Finally it strobes the final-permutation capture and holds the result in an output register until the consumer takes it.

---
 rtl/des_pkg.sv | 21 ++
 rtl/des_ks_shift_sel.sv | 31 +++
 rtl/des_iter_ctrl.sv | 120 ++++++++++++
 tb/tb_des_iter_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared types and constants for the iterative DES sequencing controller.
// Holds the controller state encoding, the round count and the encrypt
// key-schedule rotation table indexed by 0-based round number.
package des_pkg;

   localparam int DES_ROUNDS = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_FINAL = 2'd2,
      ST_DONE  = 2'd3
   } des_state_t;

   // C/D left-rotation amount applied before forming each encrypt subkey.
   localparam logic [1:0] KS_SHIFT_ENC [DES_ROUNDS] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

endpackage

// File: rtl/des_ks_shift_sel.sv
// Key-schedule rotation selector: maps (round index, mode) to C/D rotation.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
// Ports: i_rnd_idx (0..15), i_mode (0=encrypt, 1=decrypt),
//        o_ks_shift (0/1/2 positions), o_ks_dir (0=left, 1=right).
module des_ks_shift_sel
   import des_pkg::*;
(
   input  logic [3:0] i_rnd_idx,
   input  logic       i_mode,
   output logic [1:0] o_ks_shift,
   output logic       o_ks_dir
);

   // Decrypt round k walks the encrypt schedule backwards: it undoes the
   // rotation of encrypt round 16-k. 4-bit wrap of 0-k gives 16-k for k>0.
   logic [3:0] w_mirror_idx;

   assign w_mirror_idx = 4'd0 - i_rnd_idx;

   always_comb begin
      o_ks_shift = KS_SHIFT_ENC[i_rnd_idx];
      if (i_mode) begin
         // Round 0 of decrypt uses C16/D16, which equal C0/D0 (28 total shifts).
         o_ks_shift = (i_rnd_idx == 4'd0) ? 2'd0 : KS_SHIFT_ENC[w_mirror_idx];
      end
   end

   assign o_ks_dir = i_mode;

endmodule

// File: rtl/des_iter_ctrl.sv
// Sequencer for an iterative DES datapath: load, 16 rounds, final permutation.
// Latency: accept at T, rounds T+1..T+16, FP capture T+17, out_valid from T+18.
// Backpressure: holds the result in DONE until out_ready; in_ready low meanwhile.
// Ports: in_valid/in_ready/in_decrypt job handshake; ld_en, rnd_en, rnd_idx,
//        ks_shift, ks_dir, fp_en datapath controls; dp_result from datapath;
//        out_valid/out_ready/out_data result handshake; busy = not IDLE.
module des_iter_ctrl
   import des_pkg::*;
#(
   parameter int ROUNDS = DES_ROUNDS
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_decrypt,
   output logic        ld_en,
   output logic        rnd_en,
   output logic [3:0]  rnd_idx,
   output logic [1:0]  ks_shift,
   output logic        ks_dir,
   output logic        fp_en,
   input  logic [63:0] dp_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        busy
);

   localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

   des_state_t  r_state;
   des_state_t  w_state_nxt;
   logic [3:0]  r_rnd_cnt;
   logic        r_mode;
   logic [63:0] r_out_data;
   logic        r_out_valid;
   logic        w_accept;
   logic [1:0]  w_sel_shift;
   logic        w_sel_dir;

   des_ks_shift_sel u_ks_shift_sel (
      .i_rnd_idx  (r_rnd_cnt),
      .i_mode     (r_mode),
      .o_ks_shift (w_sel_shift),
      .o_ks_dir   (w_sel_dir)
   );

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      rnd_en      = 1'b0;
      fp_en       = 1'b0;
      ks_shift    = 2'd0;
      ks_dir      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_nxt = ST_ROUND;
            end
         end
         ST_ROUND: begin
            rnd_en   = 1'b1;
            ks_shift = w_sel_shift;
            ks_dir   = w_sel_dir;
            if (r_rnd_cnt == LAST_RND) begin
               w_state_nxt = ST_FINAL;
            end
         end
         ST_FINAL: begin
            fp_en       = 1'b1;
            w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_accept  = in_valid & in_ready;
   assign ld_en     = w_accept;
   // The counter parks at the last round, so rnd_idx keeps its final value
   // outside ROUND without a separate holding register.
   assign rnd_idx   = r_rnd_cnt;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign busy      = (r_state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_rnd_cnt   <= 4'd0;
         r_mode      <= 1'b0;
         r_out_data  <= 64'd0;
         r_out_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_mode    <= in_decrypt;
            r_rnd_cnt <= 4'd0;
         end else if (rnd_en && (r_rnd_cnt != LAST_RND)) begin
            r_rnd_cnt <= r_rnd_cnt + 4'd1;
         end
         if (fp_en) begin
            r_out_data  <= dp_result;
            r_out_valid <= 1'b1;
         end else if ((r_state == ST_DONE) && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_des_iter_ctrl.sv
// Bench for des_iter_ctrl: a DES datapath model driven by the controller's
// strobes, checked against a plain whole-block DES reference with a
// precomputed subkey list, plus cycle-level control checks.
module tb_des_iter_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_decrypt, ld_en, rnd_en, ks_dir, fp_en;
   logic [3:0]  rnd_idx;
   logic [1:0]  ks_shift;
   logic [63:0] dp_result, out_data;
   logic        out_valid, out_ready, busy;
   logic [63:0] tb_blk, tb_key;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   des_iter_ctrl #(.ROUNDS(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_decrypt(in_decrypt), .ld_en(ld_en), .rnd_en(rnd_en), .rnd_idx(rnd_idx),
      .ks_shift(ks_shift), .ks_dir(ks_dir), .fp_en(fp_en), .dp_result(dp_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   // ---------------- DES tables ----------------
   localparam int ENC_SEQ[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
   localparam int DEC_SEQ[16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
   localparam int IP_T[64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
      62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1,
      59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
   localparam int PC1_T[56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
      10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
      7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
   localparam int PC2_T[48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
      16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53,
      46,42,50,36,29,32};
   localparam int E_T[48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
      12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29,
      28,29,30,31,32,1};
   localparam int P_T[32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
      2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
   localparam logic [255:0] SB[8] = '{
      256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
      256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
      256'hA09E63F51DC7B428D70934A6285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
      256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
      256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
      256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
      256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
      256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

   function automatic logic [63:0] f_ip(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[63-i] = x[64-IP_T[i]];
      return r;
   endfunction

   function automatic logic [63:0] f_fp(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[64-IP_T[i]] = x[63-i];
      return r;
   endfunction

   function automatic logic [55:0] f_pc1(input logic [63:0] k);
      logic [55:0] r;
      for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_T[i]];
      return r;
   endfunction

   function automatic logic [47:0] f_pc2(input logic [55:0] cd);
      logic [47:0] r;
      for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_T[i]];
      return r;
   endfunction

   function automatic logic [31:0] f_feistel(input logic [31:0] rr, input logic [47:0] k);
      logic [47:0] e;
      logic [31:0] s;
      logic [31:0] p;
      logic [5:0]  ch;
      int row, col;
      for (int i = 0; i < 48; i++) e[47-i] = rr[32-E_T[i]];
      e = e ^ k;
      for (int i = 0; i < 8; i++) begin
         ch  = e[47-6*i -: 6];
         row = {30'd0, ch[5], ch[0]};
         col = {28'd0, ch[4:1]};
         s[31-4*i -: 4] = SB[i][255-4*(row*16+col) -: 4];
      end
      for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
      return p;
   endfunction

   function automatic logic [27:0] rol28(input logic [27:0] x, input int n);
      return (x << n) | (x >> (28 - n));
   endfunction

   function automatic logic [27:0] ror28(input logic [27:0] x, input int n);
      return (x >> n) | (x << (28 - n));
   endfunction

   // Whole-block reference: all subkeys up front, decrypt uses them reversed.
   function automatic logic [63:0] des_ref(input logic [63:0] blk, input logic [63:0] key, input logic dec);
      logic [55:0] cd;
      logic [27:0] c, d;
      logic [47:0] ks[16];
      logic [63:0] x;
      logic [31:0] l, r, t;
      cd = f_pc1(key);
      c  = cd[55:28];
      d  = cd[27:0];
      for (int i = 0; i < 16; i++) begin
         c = rol28(c, ENC_SEQ[i]);
         d = rol28(d, ENC_SEQ[i]);
         ks[i] = f_pc2({c, d});
      end
      x = f_ip(blk);
      l = x[63:32];
      r = x[31:0];
      for (int i = 0; i < 16; i++) begin
         t = r;
         r = l ^ f_feistel(r, dec ? ks[15-i] : ks[i]);
         l = t;
      end
      return f_fp({r, l});
   endfunction

   // ---------------- datapath model driven by the controller ----------------
   logic [31:0] dp_l, dp_r;
   logic [27:0] dp_c, dp_d, dp_c2, dp_d2;
   logic [47:0] dp_k;

   assign dp_c2     = ks_dir ? ror28(dp_c, int'(ks_shift)) : rol28(dp_c, int'(ks_shift));
   assign dp_d2     = ks_dir ? ror28(dp_d, int'(ks_shift)) : rol28(dp_d, int'(ks_shift));
   assign dp_k      = f_pc2({dp_c2, dp_d2});
   assign dp_result = f_fp({dp_r, dp_l});

   always @(posedge clk) begin
      if (ld_en) begin
         {dp_l, dp_r} <= f_ip(tb_blk);
         {dp_c, dp_d} <= f_pc1(tb_key);
      end else if (rnd_en) begin
         dp_c <= dp_c2;
         dp_d <= dp_d2;
         dp_l <= dp_r;
         dp_r <= dp_l ^ f_feistel(dp_r, dp_k);
      end
   end

   // ---------------- per-job observation record ----------------
   logic        ob_ld[64], ob_rnd[64], ob_fp[64], ob_ov[64], ob_inr[64], ob_dir[64];
   logic [3:0]  ob_idx[64];
   logic [1:0]  ob_sh[64];
   logic [63:0] ob_od[64];
   logic [63:0] ob_res;
   int          ob_first_ov, ob_done, ob_last;

   task automatic rec(input int c);
      ob_ld[c]  = ld_en;    ob_rnd[c] = rnd_en;   ob_fp[c]  = fp_en;
      ob_ov[c]  = out_valid; ob_inr[c] = in_ready; ob_dir[c] = ks_dir;
      ob_idx[c] = rnd_idx;  ob_sh[c]  = ks_shift; ob_od[c]  = out_data;
   endtask

   // Offers one job, optionally re-pokes in_valid at cycle 'poke', keeps
   // out_ready low for 'stall' cycles after T+18, and records every cycle.
   task automatic run_job(input logic [63:0] blk, input logic [63:0] key, input logic dec,
                          input int stall, input int poke);
      int w = 0;
      ob_first_ov = -1; ob_done = -1; ob_res = '0; ob_last = 0;
      for (int i = 0; i < 64; i++) rec(i);
      @(negedge clk);
      in_valid = 1'b1; in_decrypt = dec; tb_blk = blk; tb_key = key; out_ready = 1'b0;
      #1;
      while (!in_ready && w < 50) begin
         @(negedge clk); #1; w++;
      end
      rec(0);
      for (int c = 1; c < 64; c++) begin
         @(negedge clk);
         in_valid   = (c == poke);
         in_decrypt = ~dec;
         tb_blk     = (c == poke) ? ~blk : blk;
         tb_key     = (c == poke) ? ~key : key;
         out_ready  = (c >= 18 + stall);
         #1;
         rec(c);
         ob_last = c;
         if (out_valid && ob_first_ov < 0) ob_first_ov = c;
         if (out_valid && out_ready && ob_done < 0) begin
            ob_done = c;
            ob_res  = out_data;
         end
         if (ob_done >= 0 && c == ob_done + 1) break;
      end
      in_valid = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0; out_ready = 1'b0;
      tb_blk = '0; tb_key = '0;
      #12;
      n_checks++;
      if ({ld_en, rnd_en, fp_en, ks_shift, ks_dir, rnd_idx, busy, out_valid, out_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rnd_en=%b fp_en=%b sh=%0d dir=%b idx=%0d busy=%b ov=%b od=%h, required all zero",
                  rnd_en, fp_en, ks_shift, ks_dir, rnd_idx, busy, out_valid, out_data);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_idle: in_ready=%b busy=%b, required 1/0", in_ready, busy);
      end
      in_valid = 1'b1; #1;
      n_checks++;
      if (ld_en !== 1'b1) begin
         n_fail++; $display("FAIL reset_ld_follow: ld_en=%b, required 1", ld_en);
      end
      in_valid = 1'b0; #1;
      n_checks++;
      if (ld_en !== 1'b0) begin
         n_fail++; $display("FAIL reset_ld_drop: ld_en=%b, required 0", ld_en);
      end
   endtask

   task automatic test_encrypt_kat();
      int bad = 0;
      run_job(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 0, -1);
      n_checks++;
      if (ob_ld[0] !== 1'b1) begin n_fail++; $display("FAIL kat_accept: ld_en=%b, required 1", ob_ld[0]); end
      n_checks++;
      if (ob_first_ov !== 18) begin n_fail++; $display("FAIL kat_latency: out_valid at T+%0d, required T+18", ob_first_ov); end
      n_checks++;
      if (ob_res !== 64'h85E813540F0AB405) begin n_fail++; $display("FAIL kat_result: got %h, required 85e813540f0ab405", ob_res); end
      for (int c = 1; c <= 16; c++)
         if (ob_rnd[c] !== 1'b1 || ob_idx[c] !== 4'(c-1) || ob_sh[c] !== 2'(ENC_SEQ[c-1]) || ob_dir[c] !== 1'b0) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL kat_round_ctrl: %0d bad round cycles, required 0", bad); end
      n_checks++;
      if (ob_fp[17] !== 1'b1 || ob_rnd[17] !== 1'b0 || ob_idx[17] !== 4'd15 || ob_idx[18] !== 4'd15) begin
         n_fail++; $display("FAIL kat_final: fp_en=%b rnd_en=%b idx=%0d, required 1/0/15", ob_fp[17], ob_rnd[17], ob_idx[17]);
      end
      bad = 0;
      for (int c = 0; c <= ob_last; c++) begin
         if (int'(ob_ld[c]) + int'(ob_rnd[c]) + int'(ob_fp[c]) > 1) bad++;
         if ((c < 1 || c > 16) && (ob_rnd[c] !== 1'b0 || ob_sh[c] !== 2'd0 || ob_dir[c] !== 1'b0)) bad++;
         if (c > 0 && ob_ld[c] !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL kat_exclusive: %0d bad cycles, required 0", bad); end
      n_checks++;
      if (ob_done !== 18 || ob_inr[19] !== 1'b1) begin
         n_fail++; $display("FAIL kat_handshake: done at T+%0d in_ready(T+19)=%b, required T+18/1", ob_done, ob_inr[19]);
      end
   endtask

   task automatic test_decrypt_seq();
      int bad = 0;
      run_job(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b1, 0, -1);
      for (int c = 1; c <= 16; c++)
         if (ob_rnd[c] !== 1'b1 || ob_sh[c] !== 2'(DEC_SEQ[c-1]) || ob_dir[c] !== 1'b1) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL dec_round_ctrl: %0d bad round cycles, required 0", bad); end
      n_checks++;
      if (ob_res !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL dec_result: got %h, required 0123456789abcdef", ob_res); end
      n_checks++;
      if (ob_first_ov !== 18) begin n_fail++; $display("FAIL dec_latency: T+%0d, required T+18", ob_first_ov); end
   endtask

   task automatic test_backpressure();
      logic [63:0] blk, key, exp;
      int bad = 0;
      blk = {$urandom, $urandom}; key = {$urandom, $urandom};
      exp = des_ref(blk, key, 1'b0);
      run_job(blk, key, 1'b0, 5, -1);
      for (int c = 18; c <= 23; c++)
         if (ob_ov[c] !== 1'b1 || ob_od[c] !== exp || ob_inr[c] !== 1'b0) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL bp_hold: %0d bad stalled cycles, required 0", bad); end
      n_checks++;
      if (ob_done !== 23 || ob_inr[24] !== 1'b1 || ob_ov[24] !== 1'b0) begin
         n_fail++; $display("FAIL bp_release: done T+%0d in_ready(T+24)=%b ov=%b, required T+23/1/0", ob_done, ob_inr[24], ob_ov[24]);
      end
      n_checks++;
      if (ob_res !== exp) begin n_fail++; $display("FAIL bp_result: got %h, required %h", ob_res, exp); end
   endtask

   task automatic test_busy_ignore();
      logic [63:0] blk, key, exp;
      int lds = 0;
      blk = {$urandom, $urandom}; key = {$urandom, $urandom};
      exp = des_ref(blk, key, 1'b0);
      run_job(blk, key, 1'b0, 0, 5);
      for (int c = 1; c <= ob_last; c++) if (ob_ld[c] !== 1'b0 || ob_inr[c] !== (c == ob_last)) lds++;
      n_checks++;
      if (ob_ld[5] !== 1'b0 || lds != 0) begin n_fail++; $display("FAIL busy_no_ld: ld_en(T+5)=%b bad=%0d, required 0/0", ob_ld[5], lds); end
      n_checks++;
      if (ob_res !== exp || ob_first_ov !== 18) begin
         n_fail++; $display("FAIL busy_result: got %h at T+%0d, required %h at T+18", ob_res, ob_first_ov, exp);
      end
   endtask

   task automatic test_reset_mid_round();
      int ov = 0, not_idle = 0;
      @(negedge clk);
      in_valid = 1'b1; in_decrypt = 1'b0; tb_blk = {$urandom, $urandom}; tb_key = {$urandom, $urandom}; out_ready = 1'b1;
      #1;
      n_checks++;
      if (ld_en !== 1'b1) begin n_fail++; $display("FAIL rst_accept: ld_en=%b, required 1", ld_en); end
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk); in_valid = 1'b0;
      end
      #1;
      n_checks++;
      if (rnd_en !== 1'b1 || rnd_idx !== 4'd7) begin n_fail++; $display("FAIL rst_pre: rnd_en=%b idx=%0d, required 1/7", rnd_en, rnd_idx); end
      rst_n = 1'b0; #1;
      n_checks++;
      if ({ld_en, rnd_en, fp_en, ks_shift, ks_dir, rnd_idx, busy, out_valid, out_data} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: rnd_en=%b sh=%0d dir=%b idx=%0d busy=%b ov=%b od=%h, required all zero",
                  rnd_en, ks_shift, ks_dir, rnd_idx, busy, out_valid, out_data);
      end
      @(negedge clk); rst_n = 1'b1; #1;
      n_checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_release: in_ready=%b busy=%b, required 1/0", in_ready, busy); end
      for (int c = 0; c < 25; c++) begin
         @(negedge clk); #1;
         if (out_valid) ov++;
         if (!in_ready) not_idle++;
      end
      n_checks++;
      if (ov != 0 || not_idle != 0) begin n_fail++; $display("FAIL rst_no_output: out_valid cycles=%0d busy cycles=%0d, required 0/0", ov, not_idle); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] p0, k, c0;
      int acc_cyc[4], ov_cyc[4];
      logic [63:0] ov_dat[4];
      int n_acc = 0, n_ov = 0;
      p0 = {$urandom, $urandom}; k = {$urandom, $urandom};
      c0 = des_ref(p0, k, 1'b0);
      for (int i = 0; i < 4; i++) begin acc_cyc[i] = -1; ov_cyc[i] = -1; ov_dat[i] = '0; end
      for (int c = 0; c < 38; c++) begin
         @(negedge clk);
         in_valid = 1'b1; out_ready = 1'b1; tb_key = k;
         in_decrypt = (n_acc >= 1);
         tb_blk = (n_acc >= 1) ? c0 : p0;
         #1;
         if (ld_en) begin
            if (n_acc < 4) acc_cyc[n_acc] = c;
            n_acc++;
         end
         if (out_valid) begin
            if (n_ov < 4) begin ov_cyc[n_ov] = c; ov_dat[n_ov] = out_data; end
            n_ov++;
         end
      end
      @(negedge clk); in_valid = 1'b0;
      n_checks++;
      if (n_acc != 2 || acc_cyc[0] != 0 || acc_cyc[1] != 19) begin
         n_fail++; $display("FAIL b2b_accepts: %0d accepts at T+%0d,T+%0d, required 2 at T+0,T+19", n_acc, acc_cyc[0], acc_cyc[1]);
      end
      n_checks++;
      if (n_ov != 2 || ov_cyc[0] != 18 || ov_cyc[1] != 37) begin
         n_fail++; $display("FAIL b2b_outputs: %0d out_valid cycles at T+%0d,T+%0d, required 2 at T+18,T+37", n_ov, ov_cyc[0], ov_cyc[1]);
      end
      n_checks++;
      if (ov_dat[0] !== c0 || ov_dat[1] !== p0) begin
         n_fail++; $display("FAIL b2b_modes: got %h,%h, required %h,%h", ov_dat[0], ov_dat[1], c0, p0);
      end
   endtask

   task automatic test_random();
      logic [63:0] blk, key, exp;
      logic dec;
      int stall;
      for (int j = 0; j < 6; j++) begin
         blk = {$urandom, $urandom}; key = {$urandom, $urandom};
         dec = 1'($urandom_range(0, 1)); stall = $urandom_range(0, 3);
         exp = des_ref(blk, key, dec);
         run_job(blk, key, dec, stall, -1);
         n_checks++;
         if (ob_res !== exp) begin n_fail++; $display("FAIL rand_result[%0d]: got %h, required %h (dec=%b)", j, ob_res, exp, dec); end
         n_checks++;
         if (ob_first_ov !== 18 || ob_done !== 18 + stall) begin
            n_fail++; $display("FAIL rand_timing[%0d]: ov T+%0d done T+%0d, required T+18/T+%0d", j, ob_first_ov, ob_done, 18 + stall);
         end
      end
   endtask

   initial begin
      test_reset();
      test_encrypt_kat();
      test_decrypt_seq();
      test_backpressure();
      test_busy_ignore();
      test_reset_mid_round();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
